// File: rtl/fifo_umbral.sv
// fifo_umbral: 4-deep synchronous FIFO with programmable almost-full /
// almost-empty thresholds, a sticky overflow/underflow error flag and a
// two-state INIT/ACTIVE controller driven by the transmit-layer FSM.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int U_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [U_WIDTH-1:0]    umbral_alto,
  input  logic [U_WIDTH-1:0]    umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Common width for the unsigned threshold compares, so neither side truncates.
  localparam int CW = (U_WIDTH > ADDR_WIDTH + 1) ? U_WIDTH : ADDR_WIDTH + 1;

  typedef enum logic {
    StInit   = 1'b0,
    StActive = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0]   rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]   dataOut_q, dataOut_d;
  logic                    validOut_q, validOut_d;
  logic                    error_q, error_d;
  logic [U_WIDTH-1:0]      alto_q, alto_d;
  logic [U_WIDTH-1:0]      bajo_q, bajo_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic isActive;
  logic isEmpty;
  logic isFull;
  logic doPush;
  logic doPop;
  logic overflow;
  logic underflow;

  // Status flags come only from registered count and thresholds, so they
  // never glitch with push/pop.
  assign isEmpty      = (count_q == '0);
  assign isFull       = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty        = isEmpty;
  assign full         = isFull;
  assign almost_full  = (CW'(count_q) >= CW'(alto_q));
  assign almost_empty = (CW'(count_q) <= CW'(bajo_q));

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;
  assign count     = count_q;
  assign error     = error_q;

  // Decode which requests are honoured this cycle; a full FIFO still accepts
  // a push when a pop frees a slot on the same edge.
  always_comb begin
    isActive  = (state_q == StActive) && !init;
    doPop     = isActive && pop && !isEmpty;
    doPush    = isActive && push && (!isFull || pop);
    overflow  = isActive && push && !pop && isFull;
    underflow = isActive && pop && isEmpty;
  end

  // Next-state logic: init flushes and reloads thresholds from either state,
  // INIT spends one cycle ignoring traffic, ACTIVE moves data.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    dataOut_d  = dataOut_q;
    validOut_d = 1'b0;
    error_d    = error_q;
    alto_d     = alto_q;
    bajo_d     = bajo_q;
    if (init) begin
      state_d = StInit;
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      error_d = 1'b0;
      alto_d  = umbral_alto;
      bajo_d  = umbral_bajo;
    end else if (state_q == StInit) begin
      state_d = StActive;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
      end
      if (doPop) begin
        rdPtr_d    = rdPtr_q + ADDR_WIDTH'(1);
        dataOut_d  = mem_q[rdPtr_q];
        validOut_d = 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
        default: count_d = count_q;
      endcase
      if (overflow || underflow) begin
        error_d = 1'b1;
      end
    end
  end

  // Control state, pointers, occupancy, outputs and thresholds; reset lands
  // in INIT with the default thresholds DEPTH-1 / 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      dataOut_q  <= '0;
      validOut_q <= 1'b0;
      error_q    <= 1'b0;
      alto_q     <= U_WIDTH'(DEPTH - 1);
      bajo_q     <= U_WIDTH'(1);
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
      error_q    <= error_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

endmodule
